// File: rtl/icache_refill_ctrl.sv
// I-cache miss refill sequencer: issues one line request, streams the returned
// beats into the data array, writes the tag and replays the missing word to Fetch3.
module icache_refill_ctrl #(
  parameter  int LINE_BYTES = 32,
  parameter  int BEATS      = LINE_BYTES / 4,
  localparam int IDX_W      = $clog2(BEATS),
  localparam int OFF_W      = $clog2(LINE_BYTES)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_miss_req,
  input  logic [31:0]      i_miss_pc,
  output logic             o_busy,
  output logic             o_mem_req_valid,
  input  logic             i_mem_req_ready,
  output logic [31:0]      o_mem_req_addr,
  input  logic             i_mem_resp_valid,
  input  logic [31:0]      i_mem_resp_data,
  output logic             o_fill_we,
  output logic [IDX_W-1:0] o_fill_idx,
  output logic [31:0]      o_fill_data,
  output logic [31:0]      o_fill_line_addr,
  output logic             o_tag_we,
  output logic             o_miss_done,
  output logic [31:0]      o_miss_data,
  output logic [31:0]      o_miss_pc
);

  typedef enum logic [2:0] {IDLE, REQ, FILL, DONE, DRAIN} state_t;

  state_t           state_r;
  logic [IDX_W-1:0] cnt_r;
  logic             last_r;   // last beat already written; one more cycle before leaving
  logic [IDX_W-1:0] word_off_s;
  logic             beat_last_s;

  assign word_off_s  = o_miss_pc[OFF_W-1:2];
  assign beat_last_s = (cnt_r == IDX_W'(BEATS - 1));

  // Refill sequencer with all outputs registered
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r          <= IDLE;
      cnt_r            <= '0;
      last_r           <= 1'b0;
      o_busy           <= 1'b0;
      o_mem_req_valid  <= 1'b0;
      o_mem_req_addr   <= '0;
      o_fill_we        <= 1'b0;
      o_fill_idx       <= '0;
      o_fill_data      <= '0;
      o_fill_line_addr <= '0;
      o_tag_we         <= 1'b0;
      o_miss_done      <= 1'b0;
      o_miss_data      <= '0;
      o_miss_pc        <= '0;
    end else begin
      o_fill_we   <= 1'b0;
      o_tag_we    <= 1'b0;
      o_miss_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (i_miss_req && !i_flush) begin
            state_r          <= REQ;
            o_busy           <= 1'b1;
            o_mem_req_valid  <= 1'b1;
            o_miss_pc        <= i_miss_pc;
            o_mem_req_addr   <= {i_miss_pc[31:OFF_W], {OFF_W{1'b0}}};
            o_fill_line_addr <= {i_miss_pc[31:OFF_W], {OFF_W{1'b0}}};
            cnt_r            <= '0;
            last_r           <= 1'b0;
          end
        end
        REQ: begin
          // once the handshake has happened the memory will stream the line, so a
          // flush in the same cycle can only turn the refill into a drain
          if (i_mem_req_ready) begin
            o_mem_req_valid <= 1'b0;
            state_r         <= i_flush ? DRAIN : FILL;
          end else if (i_flush) begin
            o_mem_req_valid <= 1'b0;
            o_busy          <= 1'b0;
            state_r         <= IDLE;
          end
        end
        FILL, DRAIN: begin
          if (last_r) begin
            last_r  <= 1'b0;
            o_busy  <= 1'b0;
            state_r <= IDLE;
          end else begin
            if (i_mem_resp_valid) begin
              o_fill_we   <= 1'b1;
              o_fill_idx  <= cnt_r;
              o_fill_data <= i_mem_resp_data;
              cnt_r       <= cnt_r + IDX_W'(1);
              if (cnt_r == word_off_s) begin
                o_miss_data <= i_mem_resp_data;
              end
            end
            if (i_mem_resp_valid && beat_last_s) begin
              o_tag_we <= 1'b1;
              last_r   <= 1'b1;
              state_r  <= (state_r == FILL && !i_flush) ? DONE : DRAIN;
            end else if (i_flush) begin
              state_r <= DRAIN;
            end
          end
        end
        DONE: begin
          // first DONE cycle coincides with the last fill write; a flush there masks the replay
          if (last_r) begin
            last_r      <= 1'b0;
            o_miss_done <= !i_flush;
          end else begin
            o_busy  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r         <= IDLE;
          o_busy          <= 1'b0;
          o_mem_req_valid <= 1'b0;
          last_r          <= 1'b0;
        end
      endcase
    end
  end

endmodule
